// File: rtl/cfa_demosaic_sched.sv
// Raster-scan scheduler for a 5x5 Bayer demosaic window datapath: advance control,
// centre tagging, frame-end flush and global stall. Define SCHED_BORDER_SKIP_EN to emit interior centres only.
module cfa_demosaic_sched #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int CW    = 12,
   parameter int LAT   = 2,
   parameter int BAYER = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          s_valid,
   output logic          s_ready,
   output logic          pad,
   output logic          pipe_en,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [1:0]    site,
   output logic          border,
   output logic [CW-1:0] row,
   output logic [CW-1:0] col,
   output logic          busy,
   output logic          frame_done
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int OFF  = 2 * IMG_W + 2;
   localparam int KW   = $clog2(NPIX + OFF + 1);

   localparam logic [KW-1:0] K_LAST_PIX = KW'(NPIX - 1);
   localparam logic [KW-1:0] K_LAST     = KW'(NPIX + OFF - 1);
   localparam logic [KW-1:0] K_OFF      = KW'(OFF);
   localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
   localparam logic [CW-1:0] ROW_LAST   = CW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_HI     = CW'(IMG_W - 3);
   localparam logic [CW-1:0] ROW_HI     = CW'(IMG_H - 3);
   localparam logic [CW-1:0] EDGE       = CW'(2);
   localparam logic [1:0]    PHASE      = 2'(BAYER);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

   typedef struct packed {
      logic          valid;
      logic [1:0]    site;
      logic          border;
      logic [CW-1:0] row;
      logic [CW-1:0] col;
   } tag_t;

   state_t        state;
   logic [KW-1:0] k;
   logic [CW-1:0] c_row;
   logic [CW-1:0] c_col;
   tag_t          pipe [LAT];
   tag_t          tag_in;
   logic          adv;
   logic          centre_on;
   logic          c_border;
   logic          stall;
   logic          upstream_busy;
   logic          done_cond;

   // A blocked output freezes every stage, so results can never overtake each other.
   assign stall   = pipe[LAT-1].valid & ~m_ready;
   assign busy    = (state != IDLE);
   assign pipe_en = busy & ~stall;
   assign s_ready = (state == RUN) & pipe_en;
   assign pad     = (state == FLUSH);

   assign adv       = (s_valid & s_ready) | (pad & pipe_en);
   assign centre_on = (k >= K_OFF);
   assign c_border  = (c_row < EDGE) | (c_row > ROW_HI) | (c_col < EDGE) | (c_col > COL_HI);

   // NOTE: combinational blocks assign a default first so no path can infer a latch.
   always_comb begin
      tag_in      = '0;
      tag_in.site = {c_row[0], c_col[0]} ^ PHASE;
      tag_in.row  = c_row;
      tag_in.col  = c_col;
`ifdef SCHED_BORDER_SKIP_EN
      tag_in.valid  = adv & centre_on & ~c_border;
`else
      tag_in.valid  = adv & centre_on;
      tag_in.border = c_border;
`endif
   end

   always_comb begin
      upstream_busy = 1'b0;
      for (int i = 0; i < LAT - 1; i++) begin
         upstream_busy = upstream_busy | pipe[i].valid;
      end
   end

   // Frame is complete once only the output stage can hold a result and it leaves now.
   assign done_cond = (state == DRAIN) & ~upstream_busy & ~stall;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         k          <= '0;
         c_row      <= '0;
         c_col      <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  k     <= '0;
                  c_row <= '0;
                  c_col <= '0;
               end
            end
            RUN, FLUSH: begin
               if (adv) begin
                  k <= k + 1'b1;
                  if (state == RUN && k == K_LAST_PIX) state <= FLUSH;
                  if (state == FLUSH && k == K_LAST) state <= DRAIN;
                  if (centre_on) begin
                     if (c_col == COL_LAST) begin
                        c_col <= '0;
                        c_row <= (c_row == ROW_LAST) ? '0 : c_row + 1'b1;
                     end else begin
                        c_col <= c_col + 1'b1;
                     end
                  end
               end
            end
            DRAIN: begin
               if (done_cond) begin
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: the tag pipe is a handful of flops, so it is reset to drop stale results on rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end else if (pipe_en) begin
         pipe[0] <= tag_in;
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign m_valid = pipe[LAT-1].valid;
   assign site    = pipe[LAT-1].site;
   assign border  = pipe[LAT-1].border;
   assign row     = pipe[LAT-1].row;
   assign col     = pipe[LAT-1].col;

endmodule

// File: tb/tb_cfa_demosaic_sched.sv
// Directed bench for cfa_demosaic_sched on an 8x6 frame (RGGB main instance, BGGR site-only instance).
module tb_cfa_demosaic_sched;

   localparam int W   = 8;
   localparam int H   = 6;
   localparam int MAX_CYC = 400;
`ifdef SCHED_BORDER_SKIP_EN
   localparam int EXP_N     = 8;
   localparam int FIRST_ADV = 36;
   localparam int RST_BEAT  = 5;
`else
   localparam int EXP_N     = 48;
   localparam int FIRST_ADV = 18;
   localparam int RST_BEAT  = 20;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic s_valid = 1'b0;
   logic m_ready = 1'b1;

   logic        s_ready, pad, pipe_en, m_valid, border, busy, frame_done;
   logic [1:0]  site;
   logic [11:0] row, col;
   logic        x3_s_ready, x3_pad, x3_pipe_en, x3_m_valid, x3_border, x3_busy, x3_frame_done;
   logic [1:0]  x3_site;
   logic [11:0] x3_row, x3_col;

   int total = 0;
   int bad   = 0;

   int r_row [64];
   int r_col [64];
   int r_site [64];
   int r_site3 [64];
   int r_bord [64];
   int nb, n_acc, n_pad, adv_cnt, first_adv_cyc, first_mv_cyc;
   int n_done, done_cyc, last_beat_cyc, stall_obs;
   logic busy_at_done;
   bit finished;

   always #5 clk = ~clk;

   cfa_demosaic_sched #(.IMG_W(W), .IMG_H(H), .CW(12), .LAT(2), .BAYER(0)) dut (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
      .pad(pad), .pipe_en(pipe_en), .m_valid(m_valid), .m_ready(m_ready),
      .site(site), .border(border), .row(row), .col(col), .busy(busy),
      .frame_done(frame_done)
   );

   cfa_demosaic_sched #(.IMG_W(W), .IMG_H(H), .CW(12), .LAT(2), .BAYER(3)) dut3 (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(x3_s_ready),
      .pad(x3_pad), .pipe_en(x3_pipe_en), .m_valid(x3_m_valid), .m_ready(m_ready),
      .site(x3_site), .border(x3_border), .row(x3_row), .col(x3_col), .busy(x3_busy),
      .frame_done(x3_frame_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string pfx);
      check({pfx, "_s_ready"}, s_ready, 0);
      check({pfx, "_pad"}, pad, 0);
      check({pfx, "_pipe_en"}, pipe_en, 0);
      check({pfx, "_m_valid"}, m_valid, 0);
      check({pfx, "_site"}, site, 0);
      check({pfx, "_border"}, border, 0);
      check({pfx, "_row"}, row, 0);
      check({pfx, "_col"}, col, 0);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_frame_done"}, frame_done, 0);
   endtask

   // One frame: optional s_valid gaps, a 5-cycle m_ready drop after beat stall_beat,
   // a stray start pulse at cycle start_at, or an async reset after beat rst_beat.
   task automatic run_frame(input bit gap, input int stall_beat, input int start_at,
                            input int rst_beat);
      int  held_row, held_col, stall_left;
      bit  stalled, stall_pending;
      nb = 0; n_acc = 0; n_pad = 0; adv_cnt = 0; first_adv_cyc = -1; first_mv_cyc = -1;
      n_done = 0; done_cyc = -1; last_beat_cyc = -1; stall_obs = 0; busy_at_done = 1'b1;
      finished = 1'b0; stall_left = 0; stalled = 1'b0; stall_pending = 1'b0;
      held_row = 0; held_col = 0;
      @(posedge clk); #1;
      start = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
      for (int cyc = 0; cyc < MAX_CYC && !finished; cyc++) begin
         @(posedge clk); #1;
         start   = (cyc == start_at);
         s_valid = gap ? ~s_valid : 1'b1;
         if (stall_pending) begin
            m_ready = 1'b0; stall_left = 5; stall_pending = 1'b0;
         end else if (stall_left == 0) begin
            m_ready = 1'b1;
         end
         @(negedge clk);
         if (s_valid && s_ready) n_acc++;
         if (pad && pipe_en) n_pad++;
         if ((s_valid && s_ready) || (pad && pipe_en)) begin
            if (adv_cnt == FIRST_ADV) first_adv_cyc = cyc;
            adv_cnt++;
         end
         if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
         if (m_valid && m_ready) begin
            if (nb < 64) begin
               r_row[nb] = int'(row); r_col[nb] = int'(col); r_site[nb] = int'(site);
               r_site3[nb] = int'(x3_site); r_bord[nb] = int'(border);
            end
            nb++;
            last_beat_cyc = cyc;
         end
         if (!m_ready && stall_left > 0) begin
            stall_obs++;
            check("stall_pipe_en", pipe_en, 0);
            check("stall_s_ready", s_ready, 0);
            check("stall_m_valid", m_valid, 1);
            if (stall_left == 5) begin
               held_row = int'(row); held_col = int'(col);
            end else begin
               check("stall_row_hold", row, held_row);
               check("stall_col_hold", col, held_col);
            end
            stall_left--;
         end
         if (stall_beat >= 0 && !stalled && nb == stall_beat) begin
            stall_pending = 1'b1; stalled = 1'b1;
         end
         if (frame_done) begin
            n_done++; done_cyc = cyc; busy_at_done = busy; finished = 1'b1;
         end
         if (rst_beat >= 0 && nb == rst_beat && !finished) begin
            #2 rst = 1'b1;
            #1 check_idle("rst_mid");
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0; rst = 1'b0;
            repeat (3) @(negedge clk);
            check("rst_mid_busy_after", busy, 0);
            check("rst_mid_no_done", frame_done, 0);
            finished = 1'b1;
         end
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      check("frame_finished", finished, 1);
   endtask

   task automatic check_beats(input string pfx);
      int lim;
      int er, ec, eb, es;
      check({pfx, "_beats"}, nb, EXP_N);
      lim = (nb < EXP_N) ? nb : EXP_N;
      for (int i = 0; i < lim; i++) begin
`ifdef SCHED_BORDER_SKIP_EN
         er = 2 + i / 4; ec = 2 + i % 4; eb = 0;
`else
         er = i / W; ec = i % W;
         eb = (er < 2 || er > H - 3 || ec < 2 || ec > W - 3) ? 1 : 0;
`endif
         es = ((er % 2) << 1) | (ec % 2);
         check({pfx, "_row"}, r_row[i], er);
         check({pfx, "_col"}, r_col[i], ec);
         check({pfx, "_site"}, r_site[i], es);
         check({pfx, "_site_bggr"}, r_site3[i], es ^ 3);
         check({pfx, "_border"}, r_bord[i], eb);
      end
   endtask

   initial begin
      // Reset: asserted asynchronously between edges, start held during reset.
      #2 rst = 1'b1;
      #1 check_idle("reset");
      @(negedge clk); start = 1'b1;
      @(negedge clk); check("reset_start_ignored", busy, 0);
      start = 1'b0;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_release_busy", busy, 0);
      check("reset_release_pipe_en", pipe_en, 0);

      // Full frame, continuous stream, no backpressure.
      run_frame(1'b0, -1, -1, -1);
      check("full_accepts", n_acc, 48);
      check("full_pad_cycles", n_pad, 18);
      check("full_first_latency", first_mv_cyc - first_adv_cyc, 2);
      check("full_done_count", n_done, 1);
      check("full_busy_at_done", busy_at_done, 0);
`ifdef SCHED_BORDER_SKIP_EN
      check("skip_done_after_last", done_cyc > last_beat_cyc, 1);
      check("skip_first_row", r_row[0], 2);
      check("skip_first_col", r_col[0], 2);
      check("skip_last_row", r_row[7], 3);
      check("skip_last_col", r_col[7], 5);
`else
      check("full_done_after_last", (done_cyc - last_beat_cyc) >= 0 &&
                                    (done_cyc - last_beat_cyc) <= 1, 1);
      check("first_row", r_row[0], 0);
      check("first_col", r_col[0], 0);
      check("site_r0c0", r_site[0], 0);
      check("site_r0c1", r_site[1], 1);
      check("site_r1c0", r_site[8], 2);
      check("site_r1c1", r_site[9], 3);
      check("site3_r0c0", r_site3[0], 3);
      check("site3_r0c1", r_site3[1], 2);
      check("border_1_3", r_bord[11], 1);
      check("border_2_2", r_bord[18], 0);
      check("border_3_5", r_bord[29], 0);
      check("border_3_6", r_bord[30], 1);
      check("border_4_4", r_bord[36], 1);
`endif
      check_beats("full");

      // Backpressure: m_ready dropped for 5 cycles mid-frame.
      run_frame(1'b0, 3, -1, -1);
      check("bp_stall_cycles", stall_obs, 5);
      check("bp_accepts", n_acc, 48);
      check("bp_done_count", n_done, 1);
      check_beats("bp");

      // Input gaps plus a stray start pulse while running.
      run_frame(1'b1, -1, 10, -1);
      check("gap_accepts", n_acc, 48);
      check("gap_pad_cycles", n_pad, 18);
      check("gap_done_count", n_done, 1);
      check_beats("gap");

      // Reset mid-frame, then a clean frame to show recovery.
      run_frame(1'b0, -1, -1, RST_BEAT);
      check("rst_mid_done_count", n_done, 0);
      run_frame(1'b0, -1, -1, -1);
      check("recover_done_count", n_done, 1);
      check_beats("recover");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cfa_demosaic_sched.md
Name: cfa_demosaic_sched

Overview:
- Raster-scan scheduler for the 5x5 Bayer demosaic window datapath.
- Accepts a pixel stream and advances line buffers and window registers.
- Tags each window centre with its Bayer site (R, G-on-R-row, G-on-B-row, B) so the RB-on-G / RB-on-BR sum stages pick the right equations.
- Tracks border positions, flushes the trailing two lines at frame end, and applies one stall-all backpressure enable to the whole datapath pipeline.

Parameters:
- IMG_W, 640, frame width in pixels (>=5)
- IMG_H, 480, frame height in lines (>=5)
- CW, 12, row/col counter width
- LAT, 2, datapath register stages between window advance and result (>=1)
- BAYER, 0, CFA phase of pixel (0,0): 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle pulse, begin frame
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid&s_ready
- pad  out  1  line buffers insert zero instead of s_data (flush)
- pipe_en  out  1  enable for line buffers, window regs and all LAT datapath regs
- m_valid  out  1  result valid
- m_ready  in  1  downstream accept
- site  out  2  Bayer site of m-side centre: 0=R, 1=G on R row, 2=G on B row, 3=B
- border  out  1  m-side centre within 2 px of any frame edge
- row  out  CW  m-side centre row
- col  out  CW  m-side centre column
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse on last result accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0, FSM=IDLE, counters 0, valid pipe cleared.
- pipe_en = ~(m_valid & ~m_ready). This is a global stall: nothing in the datapath moves while the output is blocked.
- FSM states:
  - IDLE: start -> RUN. Clear advance count k and the centre counters.
  - RUN: s_ready = pipe_en. Each accepted pixel is an advance; k++. After the advance with k = IMG_W*IMG_H-1 -> FLUSH.
  - FLUSH: pad=1, s_ready=0. Advance on every cycle with pipe_en=1. After OFF = 2*IMG_W+2 flush advances -> DRAIN.
  - DRAIN: no advances. Wait until the last result is accepted, then frame_done=1 for one cycle -> IDLE.
- busy = (state != IDLE). start is ignored when busy.
- Centre tracking:
  - Advance number k >= OFF produces centre index k-OFF.
  - Centre row/col counters increment (col wraps at IMG_W-1 to 0 and increments row) on each advance with k >= OFF.
- Output pipeline:
  - A LAT-deep shift register of {valid, site, border, row, col}, shifted only when pipe_en=1.
  - Stage 0 is loaded with valid = (advance & k>=OFF).
  - The last stage drives the m_* outputs, so a result appears LAT enabled cycles after its advance.
  - The m-side fields are held stable while m_valid & ~m_ready.
- site = {row[0],col[0]} XOR BAYER[1:0], computed on centre counters.
- border = (row<2) | (row>IMG_H-3) | (col<2) | (col>IMG_W-3).
- Counters never exceed their frame bounds. Centre count reaches exactly IMG_W*IMG_H.
- Simultaneous s_valid and stall: no accept, no advance.
- rst mid-frame: immediate return to IDLE, valid pipe cleared, no frame_done.

Optional Feature:
- Macro: SCHED_BORDER_SKIP_EN.
- Defined:
  - Stage-0 valid is additionally gated by ~border.
  - Only (IMG_W-4)*(IMG_H-4) results are emitted and the border output is tied 0.
  - Window advances and flush length are unchanged.
  - frame_done fires when the last interior result (IMG_H-3, IMG_W-3) is accepted. If nothing is pending, it fires at the end of FLUSH.
- Not defined: all IMG_W*IMG_H results are emitted, with border flagged.

Test Plan:
- Reset: assert rst asynchronously mid-clock -> all outputs 0 immediately; busy=0; start while rst=1 ignored.
- Full frame (IMG_W=8, IMG_H=6, LAT=2, m_ready=1, s_valid=1):
  - 48 accepts, then 18 pad cycles.
  - First m_valid 2 cycles after advance #18, at row=0 col=0.
  - Exactly 48 m_valid beats, then one frame_done.
- Site sequence:
  - BAYER=0: row 0 gives 0,1,0,1...; row 1 gives 2,3,2,3.
  - BAYER=3: row 0 gives 3,2,3,2.
- Backpressure: drop m_ready for 5 cycles mid-frame -> pipe_en=0 and s_ready=0 for 5 cycles; m_valid/site/row/col held; no beat lost or duplicated (48 total).
- Border (8x6): (1,3)->1, (2,2)->0, (3,5)->0, (3,6)->1, (4,4)->1.
- Gaps and skip:
  - s_valid toggling 1/0 -> same 48 results in order.
  - With SCHED_BORDER_SKIP_EN: 8 beats, rows 2-3, cols 2-5.
  - start pulse during RUN ignored.
  - rst at centre 20 -> IDLE, no frame_done.
